gb_cpu_instr_fetch: RTL

- Front end of the schedule protocol: the producer of the opcode stream that the instruction scheduler's schedules consume.
- On the fetch-overlap M-cycle, it does one of the following:
  - latches the next opcode from the data bus,
  - injects an interrupt-dispatch pseudo-opcode, or
  - parks the core in HALT.
- Tracks the CB prefix, the halt bug, and interrupt priority.
- Sits between the data-bus input latch and the decoder that builds schedule_t.
- One clk edge equals one M-cycle.

---
 rtl/gb_cpu_instr_fetch_pkg.sv | 30 +++
 rtl/gb_cpu_instr_fetch_if.sv | 36 +++
 rtl/gb_cpu_instr_fetch_prioritizer.sv | 32 +++
 rtl/gb_cpu_instr_fetch.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gb_cpu_instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end:
// fetch states, interrupt bit names and the default dispatch constants.
package gb_cpu_instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HALTED   = 2'd1,
        DISPATCH = 2'd2
    } fetch_state_t;

    // Bit positions in IE/IF, highest priority first.
    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_bit_t;

    localparam logic [7:0] IRQ_PSEUDO_OPCODE_DEF = 8'hD3;
    localparam logic [7:0] VECTOR_BASE_DEF       = 8'h40;
    localparam int         VECTOR_STRIDE_DEF     = 8;

    function automatic logic [7:0] irq_vector_of(input logic [7:0] base,
                                                 input int stride,
                                                 input logic [2:0] idx);
        return base + 8'(stride) * {5'b0, idx};
    endfunction

endpackage

// File: rtl/gb_cpu_instr_fetch_if.sv
// Bus bundle between the fetch unit, the data-bus latch, the interrupt
// registers and the decoder. Inputs are level signals sampled on each M-cycle edge.
interface gb_cpu_instr_fetch_if;
    import gb_cpu_instr_fetch_pkg::*;

    logic [7:0]   data_bus_i;
    logic         m_cycle_last;
    logic         cb_prefix_i;
    logic         halt_req;
    logic         ime;
    logic [4:0]   ie_reg;
    logic [4:0]   if_reg;
    logic [7:0]   opcode_o;
    logic         cb_prefix_o;
    logic         fetch_valid_o;
    logic         irq_dispatch_o;
    logic [7:0]   irq_vector_o;
    logic [4:0]   irq_ack_o;
    logic         halted_o;
    logic         pc_hold_o;
    fetch_state_t state_dbg;

    // Fetch-unit side.
    modport master (
        input  data_bus_i, m_cycle_last, cb_prefix_i, halt_req, ime, ie_reg, if_reg,
        output opcode_o, cb_prefix_o, fetch_valid_o, irq_dispatch_o, irq_vector_o,
               irq_ack_o, halted_o, pc_hold_o, state_dbg
    );

    // Surrounding core side.
    modport slave (
        output data_bus_i, m_cycle_last, cb_prefix_i, halt_req, ime, ie_reg, if_reg,
        input  opcode_o, cb_prefix_o, fetch_valid_o, irq_dispatch_o, irq_vector_o,
               irq_ack_o, halted_o, pc_hold_o, state_dbg
    );
endinterface

// File: rtl/gb_cpu_instr_fetch_prioritizer.sv
// Combinational interrupt prioritizer: lowest pending bit wins and
// selects its one-hot acknowledge and its dispatch vector.
module gb_cpu_irq_prioritizer
    import gb_cpu_instr_fetch_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE   = VECTOR_BASE_DEF,
    parameter int         VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
    input  logic [4:0] ie_reg,
    input  logic [4:0] if_reg,
    output logic [4:0] sel,
    output logic [7:0] vector,
    output logic       any_pend
);
    logic [4:0] pend;
    logic [2:0] idx;

    assign pend     = ie_reg & if_reg;
    assign any_pend = |pend;
    assign sel      = pend & (~pend + 5'd1);

    always_comb begin
        idx = 3'd0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) idx = 3'(i);
        end
    end

    assign vector = irq_vector_of(VECTOR_BASE, VECTOR_STRIDE, idx);

endmodule

// File: rtl/gb_cpu_instr_fetch.sv
// Opcode-stream producer: on the fetch-overlap M-cycle it latches the next
// opcode, injects the interrupt-dispatch pseudo-opcode, or parks the core in HALT.
module gb_cpu_instr_fetch
    import gb_cpu_instr_fetch_pkg::*;
#(
    parameter logic [7:0] IRQ_PSEUDO_OPCODE = IRQ_PSEUDO_OPCODE_DEF,
    parameter logic [7:0] VECTOR_BASE       = VECTOR_BASE_DEF,
    parameter int         VECTOR_STRIDE     = VECTOR_STRIDE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    gb_cpu_instr_fetch_if.master   bus
);
    fetch_state_t state_q, state_d;
    logic [7:0]   opcode_q, opcode_d;
    logic         cb_q, cb_d;
    logic         fv_q, fv_d;
    logic [7:0]   vec_q, vec_d;
    logic [4:0]   ack_q, ack_d;
    logic         pch_q, pch_d;

    logic [4:0]   irq_sel;
    logic [7:0]   irq_vec;
    logic         irq_any;

    logic         do_fetch, do_dispatch, fetch_cb, fetch_hold;

    gb_cpu_irq_prioritizer #(
        .VECTOR_BASE   (VECTOR_BASE),
        .VECTOR_STRIDE (VECTOR_STRIDE)
    ) u_prio (
        .ie_reg   (bus.ie_reg),
        .if_reg   (bus.if_reg),
        .sel      (irq_sel),
        .vector   (irq_vec),
        .any_pend (irq_any)
    );

    always_comb begin
        state_d     = state_q;
        do_fetch    = 1'b0;
        do_dispatch = 1'b0;
        fetch_cb    = 1'b0;
        fetch_hold  = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (bus.m_cycle_last) begin
                    // CB and its opcode are never split by an interrupt.
                    if (bus.cb_prefix_i) begin
                        do_fetch = 1'b1;
                        fetch_cb = 1'b1;
                    end else if (bus.ime && irq_any) begin
                        do_dispatch = 1'b1;
                    end else if (bus.halt_req && irq_any) begin
                        do_fetch   = 1'b1;
                        fetch_hold = 1'b1;
                    end else if (bus.halt_req) begin
                        state_d = HALTED;
                    end else begin
                        do_fetch = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (irq_any) begin
                    if (bus.ime) begin
                        do_dispatch = 1'b1;
                    end else begin
                        do_fetch = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            DISPATCH: begin
                // IME is still visible for one cycle here, so skip the interrupt check.
                if (bus.m_cycle_last) begin
                    do_fetch = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        opcode_d = opcode_q;
        cb_d     = cb_q;
        fv_d     = 1'b0;
        vec_d    = vec_q;
        ack_d    = 5'd0;
        pch_d    = pch_q;

        if (do_dispatch) begin
            opcode_d = IRQ_PSEUDO_OPCODE;
            cb_d     = 1'b0;
            vec_d    = irq_vec;
            ack_d    = irq_sel;
            fv_d     = 1'b1;
            pch_d    = 1'b0;
        end else if (do_fetch) begin
            opcode_d = bus.data_bus_i;
            cb_d     = fetch_cb;
            fv_d     = 1'b1;
            pch_d    = fetch_hold;
        end
    end

    // Dispatch overrides the FETCH/HALTED next-state chosen above.
    fetch_state_t state_n;
    assign state_n = do_dispatch ? DISPATCH : state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            opcode_q <= 8'h00;
            cb_q     <= 1'b0;
            fv_q     <= 1'b0;
            vec_q    <= 8'h00;
            ack_q    <= 5'd0;
            pch_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            opcode_q <= opcode_d;
            cb_q     <= cb_d;
            fv_q     <= fv_d;
            vec_q    <= vec_d;
            ack_q    <= ack_d;
            pch_q    <= pch_d;
        end
    end

    assign bus.opcode_o       = opcode_q;
    assign bus.cb_prefix_o    = cb_q;
    assign bus.fetch_valid_o  = fv_q;
    assign bus.irq_dispatch_o = (state_q == DISPATCH);
    assign bus.irq_vector_o   = vec_q;
    assign bus.irq_ack_o      = ack_q;
    assign bus.halted_o       = (state_q == HALTED);
    assign bus.pc_hold_o      = pch_q;
    assign bus.state_dbg      = state_q;

endmodule
